pixel_pair_packer: RTL and testbench

Upstream feeder for the hybrid 16-bit add-reduce stage. It accepts a serial camera pixel stream and zero-extends each pixel to OUT_WIDTH. Consecutive pixels are paired into two lanes and buffered in a small FIFO. Pairs are presented on a valid/ready output that drives the reducer's I_0/I_1/WE inputs, with group and frame markers so downstream logic can align the reducer's accumulation windows.

---
 rtl/pixel_pair_packer_if.sv | 28 ++
 rtl/pixel_pair_packer.sv | 142 ++++++++++++++
 tb/tb_pixel_pair_packer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/pixel_pair_packer_if.sv
// Pixel stream in / pixel-pair stream out bundle for pixel_pair_packer.
// slave = the packer, master = the pixel source and pair consumer.
interface pixel_pair_packer_if #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned OUT_WIDTH   = 16
);
  logic [PIXEL_WIDTH-1:0] PIX_DATA;
  logic                   PIX_VALID;
  logic                   PIX_SOF;
  logic                   PIX_READY;
  logic [OUT_WIDTH-1:0]   O_0;
  logic [OUT_WIDTH-1:0]   O_1;
  logic                   WE;
  logic                   READY;
  logic                   O_SOF;
  logic                   O_LAST;
  logic [15:0]            DROP_COUNT;

  modport slave (
    input  PIX_DATA, PIX_VALID, PIX_SOF, READY,
    output PIX_READY, O_0, O_1, WE, O_SOF, O_LAST, DROP_COUNT
  );

  modport master (
    output PIX_DATA, PIX_VALID, PIX_SOF, READY,
    input  PIX_READY, O_0, O_1, WE, O_SOF, O_LAST, DROP_COUNT
  );
endinterface

// File: rtl/pixel_pair_packer.sv
// Pairs a serial pixel stream into zero-extended two-lane words through a small FIFO,
// with frame/group markers. Define PAIR_PACKER_STATS_EN to build the drop counter.
module pixel_pair_packer #(
  parameter int unsigned PIXEL_WIDTH     = 8,
  parameter int unsigned OUT_WIDTH       = 16,
  parameter int unsigned PAIRS_PER_GROUP = 4,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  pixel_pair_packer_if.slave     bus
);
  localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W  = ADDR_W + 1;
  localparam int unsigned CNT_W  = (PAIRS_PER_GROUP > 1) ? $clog2(PAIRS_PER_GROUP) : 1;

  typedef enum logic {EMPTY, HALF} state_t;

  state_t                 state, state_d;
  logic [PIXEL_WIDTH-1:0] held, held_d;
  logic                   held_sof, held_sof_d;
  logic                   push;

  logic [PIXEL_WIDTH-1:0] mem0 [FIFO_DEPTH];
  logic [PIXEL_WIDTH-1:0] mem1 [FIFO_DEPTH];
  logic                   mem_sof [FIFO_DEPTH];
  logic [ADDR_W-1:0]      wr_ptr, rd_ptr;
  logic [OCC_W-1:0]       occ;
  logic [CNT_W-1:0]       grp_cnt;

  logic             we, full, pop, accept, head_sof;
  logic [CNT_W-1:0] eff_cnt, eff_cnt_next;

  assign we       = (occ != '0);
  assign full     = (occ == OCC_W'(FIFO_DEPTH));
  assign pop      = we & bus.READY;
  assign accept   = bus.PIX_VALID & bus.PIX_READY;
  assign head_sof = we & mem_sof[rd_ptr];

  // A full FIFO only blocks the pixel that would complete a pair, unless a pop frees a slot.
  assign bus.PIX_READY = (state == EMPTY) | ~full | pop;

  // Pairing state and held first pixel
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state    <= EMPTY;
      held     <= '0;
      held_sof <= 1'b0;
    end else begin
      state    <= state_d;
      held     <= held_d;
      held_sof <= held_sof_d;
    end
  end

  // Next-state: a SOF pixel arriving in HALF restarts the pair and drops the held pixel.
  always_comb begin
    state_d    = state;
    held_d     = held;
    held_sof_d = held_sof;
    push       = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          held_d     = bus.PIX_DATA;
          held_sof_d = bus.PIX_SOF;
          state_d    = HALF;
        end
      end
      HALF: begin
        if (accept) begin
          if (bus.PIX_SOF) begin
            held_d     = bus.PIX_DATA;
            held_sof_d = 1'b1;
          end else begin
            push    = 1'b1;
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Pair storage; contents are qualified by occupancy so no reset is needed.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem0[wr_ptr]    <= held;
      mem1[wr_ptr]    <= bus.PIX_DATA;
      mem_sof[wr_ptr] <= held_sof;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // A frame-start head always counts as position 0 of its group.
  assign eff_cnt      = head_sof ? '0 : grp_cnt;
  assign eff_cnt_next = (eff_cnt == CNT_W'(PAIRS_PER_GROUP - 1)) ? '0 : eff_cnt + CNT_W'(1);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) grp_cnt <= '0;
    else if (pop) grp_cnt <= eff_cnt_next;
  end

  assign bus.WE     = we;
  assign bus.O_0    = we ? OUT_WIDTH'(mem0[rd_ptr]) : '0;
  assign bus.O_1    = we ? OUT_WIDTH'(mem1[rd_ptr]) : '0;
  assign bus.O_SOF  = head_sof;
  assign bus.O_LAST = we & (eff_cnt == CNT_W'(PAIRS_PER_GROUP - 1));

`ifdef PAIR_PACKER_STATS_EN
  logic        drop;
  logic [15:0] drop_cnt;

  assign drop = (state == HALF) & accept & bus.PIX_SOF;

  // Saturating count of discarded half-pairs
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end

  assign bus.DROP_COUNT = drop_cnt;
`else
  assign bus.DROP_COUNT = '0;
`endif

endmodule

// File: tb/tb_pixel_pair_packer.sv
// Directed bench for pixel_pair_packer: pairing, markers, backpressure, resync, reset, throughput.
module tb_pixel_pair_packer;
  logic CLK = 1'b0;
  logic RESETN = 1'b0;
  always #5 CLK = ~CLK;

  pixel_pair_packer_if #(.PIXEL_WIDTH(8), .OUT_WIDTH(16)) bus ();

  pixel_pair_packer #(
    .PIXEL_WIDTH(8), .OUT_WIDTH(16), .PAIRS_PER_GROUP(4), .FIFO_DEPTH(4)
  ) dut (
    .CLK(CLK),
    .RESETN(RESETN),
    .bus(bus)
  );

`ifdef PAIR_PACKER_STATS_EN
  localparam logic [15:0] EXP_DROPS = 16'd1;
`else
  localparam logic [15:0] EXP_DROPS = 16'd0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] got_q[$];
  logic [33:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] pr(input bit sof, input bit last, input logic [7:0] a,
                                     input logic [7:0] b);
    return {sof, last, 16'(a), 16'(b)};
  endfunction

  // Record every popped pair as {sof, last, o0, o1}
  always @(negedge CLK)
    if (RESETN && bus.WE && bus.READY)
      got_q.push_back({bus.O_SOF, bus.O_LAST, bus.O_0, bus.O_1});

  task automatic send_pix(input logic [7:0] d, input logic s, output int waits);
    waits = 0;
    bus.PIX_DATA  = d;
    bus.PIX_SOF   = s;
    bus.PIX_VALID = 1'b1;
    @(negedge CLK);
    while (!bus.PIX_READY && waits < 50) begin
      @(negedge CLK);
      waits++;
    end
    if (!bus.PIX_READY) check("pix_accept_timeout", 64'(bus.PIX_READY), 64'd1);
    @(posedge CLK);
    #1;
    bus.PIX_VALID = 1'b0;
    bus.PIX_SOF   = 1'b0;
  endtask

  task automatic do_reset();
    bus.PIX_VALID = 1'b0;
    bus.PIX_SOF   = 1'b0;
    bus.PIX_DATA  = '0;
    bus.READY     = 1'b1;
    RESETN = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESETN = 1'b1;
    @(posedge CLK);
    #1;
    got_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic compare_pairs(input string tag);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check($sformatf("%s_pair%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int w;
    bus.PIX_VALID = 1'b0;
    bus.PIX_SOF   = 1'b0;
    bus.PIX_DATA  = '0;
    bus.READY     = 1'b1;

    // Reset state
    #2;
    check("rst_we", 64'(bus.WE), 64'd0);
    check("rst_o_sof", 64'(bus.O_SOF), 64'd0);
    check("rst_o_last", 64'(bus.O_LAST), 64'd0);
    check("rst_o_0", 64'(bus.O_0), 64'd0);
    check("rst_drop", 64'(bus.DROP_COUNT), 64'd0);
    do_reset();
    check("rst_pix_ready", 64'(bus.PIX_READY), 64'd1);

    // Basic pair and one-cycle latency
    send_pix(8'h11, 1'b0, w);
    check("basic_we_half", 64'(bus.WE), 64'd0);
    send_pix(8'h22, 1'b0, w);
    check("basic_we", 64'(bus.WE), 64'd1);
    check("basic_o_0", 64'(bus.O_0), 64'h0011);
    check("basic_o_1", 64'(bus.O_1), 64'h0022);
    check("basic_o_sof", 64'(bus.O_SOF), 64'd0);
    idle(1);
    check("basic_we_after", 64'(bus.WE), 64'd0);

    // Group of four with SOF on first pixel
    do_reset();
    for (int i = 1; i <= 8; i++) send_pix(8'(i), (i == 1), w);
    idle(3);
    exp_q.push_back(pr(1, 0, 8'd1, 8'd2));
    exp_q.push_back(pr(0, 0, 8'd3, 8'd4));
    exp_q.push_back(pr(0, 0, 8'd5, 8'd6));
    exp_q.push_back(pr(0, 1, 8'd7, 8'd8));
    compare_pairs("group");

    // Backpressure: fill FIFO, hold one pixel, block the next
    do_reset();
    bus.READY = 1'b0;
    for (int i = 0; i < 9; i++) send_pix(8'(8'h21 + i), 1'b0, w);
    bus.PIX_DATA  = 8'h2A;
    bus.PIX_VALID = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check($sformatf("bp_pix_ready%0d", c), 64'(bus.PIX_READY), 64'd0);
      check($sformatf("bp_o_0_%0d", c), 64'(bus.O_0), 64'h0021);
      check($sformatf("bp_o_1_%0d", c), 64'(bus.O_1), 64'h0022);
      @(posedge CLK);
      #1;
    end
    bus.READY = 1'b1;
    @(negedge CLK);
    check("bp_pix_ready_on_pop", 64'(bus.PIX_READY), 64'd1);
    @(posedge CLK);
    #1;
    bus.PIX_VALID = 1'b0;
    idle(8);
    exp_q.push_back(pr(0, 0, 8'h21, 8'h22));
    exp_q.push_back(pr(0, 0, 8'h23, 8'h24));
    exp_q.push_back(pr(0, 0, 8'h25, 8'h26));
    exp_q.push_back(pr(0, 1, 8'h27, 8'h28));
    exp_q.push_back(pr(0, 0, 8'h29, 8'h2A));
    compare_pairs("bp");

    // Resync: SOF in HALF drops the held pixel
    do_reset();
    send_pix(8'h05, 1'b0, w);
    send_pix(8'h06, 1'b1, w);
    send_pix(8'h07, 1'b0, w);
    idle(3);
    exp_q.push_back(pr(1, 0, 8'h06, 8'h07));
    compare_pairs("resync");
    check("resync_drop", 64'(bus.DROP_COUNT), 64'(EXP_DROPS));

    // Reset mid-operation clears FIFO and group count
    do_reset();
    for (int i = 0; i < 6; i++) send_pix(8'(8'h41 + i), 1'b0, w);
    idle(3);
    got_q.delete();
    bus.READY = 1'b0;
    for (int i = 0; i < 5; i++) send_pix(8'(8'h51 + i), 1'b0, w);
    check("mid_we_before", 64'(bus.WE), 64'd1);
    #2;
    RESETN = 1'b0;
    #1;
    check("mid_we_async", 64'(bus.WE), 64'd0);
    check("mid_o_0_async", 64'(bus.O_0), 64'd0);
    @(negedge CLK);
    RESETN = 1'b1;
    @(posedge CLK);
    #1;
    got_q.delete();
    check("mid_fifo_empty", 64'(bus.WE), 64'd0);
    check("mid_pix_ready", 64'(bus.PIX_READY), 64'd1);
    send_pix(8'h31, 1'b0, w);
    send_pix(8'h32, 1'b0, w);
    check("mid_pair", 64'({bus.WE, bus.O_SOF, bus.O_LAST, bus.O_0, bus.O_1}),
          64'({1'b1, pr(0, 0, 8'h31, 8'h32)}));
    bus.READY = 1'b1;
    idle(3);
    got_q.delete();

    // Full FIFO then continuous stream with READY=1: no stalls, order kept
    do_reset();
    bus.READY = 1'b0;
    for (int i = 0; i < 8; i++) send_pix(8'(8'h61 + i), 1'b0, w);
    bus.READY = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send_pix(8'(8'h71 + i), 1'b0, w);
      check($sformatf("tput_stall%0d", i), 64'(w), 64'd0);
    end
    idle(6);
    for (int i = 0; i < 4; i++)
      exp_q.push_back(pr(0, (i == 3), 8'(8'h61 + 2 * i), 8'(8'h62 + 2 * i)));
    for (int i = 0; i < 6; i++)
      exp_q.push_back(pr(0, (i == 3), 8'(8'h71 + 2 * i), 8'(8'h72 + 2 * i)));
    compare_pairs("tput");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
